// File: rtl/ysyx_24070017_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_24070017_exec_ctrl_pkg
// Brief  : Shared types and encodings for the multi-cycle execution sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package ysyx_24070017_exec_ctrl_pkg;

    localparam int c_WORD_LENGTH = 32;
    typedef logic [c_WORD_LENGTH-1:0] word_t;

    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_INST_NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        ysyx_24070017_CTRL_FETCH = 3'd0,
        ysyx_24070017_CTRL_IWAIT = 3'd1,
        ysyx_24070017_CTRL_EXEC  = 3'd2,
        ysyx_24070017_CTRL_MREQ  = 3'd3,
        ysyx_24070017_CTRL_MWAIT = 3'd4,
        ysyx_24070017_CTRL_WB    = 3'd5,
        ysyx_24070017_CTRL_HALT  = 3'd6,
        ysyx_24070017_CTRL_ERR   = 3'd7
    } ctrl_state_t;

    // States that wait on a memory handshake and are therefore timed.
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == ysyx_24070017_CTRL_FETCH) || (s == ysyx_24070017_CTRL_IWAIT) ||
               (s == ysyx_24070017_CTRL_MREQ)  || (s == ysyx_24070017_CTRL_MWAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24070017_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module : ysyx_24070017_timeout_cnt
// Brief  : Wait-state cycle counter; flags the last allowed cycle of a wait.
// Rev    : 1.0 - initial release
// ============================================================================
module ysyx_24070017_timeout_cnt #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [TO_W-1:0] i_limit,
    output logic            o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // r_cnt holds the cycles already spent, so the current cycle is number r_cnt+1.
    assign o_expired = (r_cnt >= (i_limit - TO_W'(1)));

endmodule
`default_nettype wire

// File: rtl/ysyx_24070017_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ysyx_24070017_exec_ctrl
// Brief  : Multi-cycle fetch/execute/memory/writeback sequencer with halt and
//          bus-timeout detection.
// Rev    : 1.0 - initial release
// ============================================================================
module ysyx_24070017_exec_ctrl
    import ysyx_24070017_exec_ctrl_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    input  logic        dec_need_rd,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_resp_valid,
    output logic        pc_we,
    output logic        rf_we,
    output logic        retire,
    output logic        halted,
    output logic        bus_err
);

    localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT);

    generate
        if ((WORD_LENGTH < 32) || (TO_W > 31) || ((1 << TO_W) <= TIMEOUT)) begin : g_bad_params
            $error("exec_ctrl: WORD_LENGTH must be >= 32 and 2**TO_W must exceed TIMEOUT");
        end
    endgenerate

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic [31:0] r_inst;
    logic        w_expired;
    logic        w_in_wait;

    assign w_in_wait = is_wait_state(r_state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ysyx_24070017_CTRL_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst <= c_INST_NOP;
        end else if ((r_state == ysyx_24070017_CTRL_IWAIT) && imem_resp_valid) begin
            r_inst <= imem_resp_data;
        end
    end

    // A handshake seen on the expiring cycle takes priority over the timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ysyx_24070017_CTRL_FETCH: begin
                if (imem_req_ready)  w_next = ysyx_24070017_CTRL_IWAIT;
                else if (w_expired)  w_next = ysyx_24070017_CTRL_ERR;
            end
            ysyx_24070017_CTRL_IWAIT: begin
                if (imem_resp_valid) w_next = ysyx_24070017_CTRL_EXEC;
                else if (w_expired)  w_next = ysyx_24070017_CTRL_ERR;
            end
            ysyx_24070017_CTRL_EXEC: begin
                if (r_inst == c_INST_EBREAK)          w_next = ysyx_24070017_CTRL_HALT;
                else if (dec_is_load || dec_is_store) w_next = ysyx_24070017_CTRL_MREQ;
                else                                  w_next = ysyx_24070017_CTRL_WB;
            end
            ysyx_24070017_CTRL_MREQ: begin
                if (dmem_req_ready)  w_next = ysyx_24070017_CTRL_MWAIT;
                else if (w_expired)  w_next = ysyx_24070017_CTRL_ERR;
            end
            ysyx_24070017_CTRL_MWAIT: begin
                if (dmem_resp_valid) w_next = ysyx_24070017_CTRL_WB;
                else if (w_expired)  w_next = ysyx_24070017_CTRL_ERR;
            end
            ysyx_24070017_CTRL_WB:   w_next = ysyx_24070017_CTRL_FETCH;
            ysyx_24070017_CTRL_HALT: w_next = ysyx_24070017_CTRL_HALT;
            ysyx_24070017_CTRL_ERR:  w_next = ysyx_24070017_CTRL_ERR;
            default:                 w_next = ysyx_24070017_CTRL_FETCH;
        endcase
    end

    ysyx_24070017_timeout_cnt #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_next != r_state),
        .i_enable  (w_in_wait),
        .i_limit   (c_LIMIT),
        .o_expired (w_expired)
    );

    // FETCH is also the reset state; gating with rst keeps the request quiet during reset.
    assign imem_req_valid = rst & (r_state == ysyx_24070017_CTRL_FETCH);
    assign dmem_req_valid = (r_state == ysyx_24070017_CTRL_MREQ);
    assign pc_we          = (r_state == ysyx_24070017_CTRL_WB);
    assign retire         = (r_state == ysyx_24070017_CTRL_WB);
    assign rf_we          = (r_state == ysyx_24070017_CTRL_WB) & dec_need_rd & ~dec_is_store;
    assign halted         = (r_state == ysyx_24070017_CTRL_HALT);
    assign bus_err        = (r_state == ysyx_24070017_CTRL_ERR);
    assign inst           = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24070017_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_24070017_exec_ctrl
// Brief  : Self-checking bench for the execution sequencer (TIMEOUT=8).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24070017_exec_ctrl;

    localparam int c_TIMEOUT = 8;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] inst;
        logic        rf_we;
        logic        pc_we;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_resp_data, inst;
    logic        dec_need_rd, dec_is_load, dec_is_store;
    logic        dmem_req_valid, dmem_req_ready, dmem_resp_valid;
    logic        pc_we, rf_we, retire, halted, bus_err;

    int   n_cmp = 0;
    int   n_err = 0;
    ret_t exp_q[$];
    ret_t obs_q[$];

    always #5 clk = ~clk;

    ysyx_24070017_exec_ctrl #(
        .WORD_LENGTH (32),
        .TIMEOUT     (c_TIMEOUT),
        .TO_W        (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .dec_need_rd     (dec_need_rd),
        .dec_is_load     (dec_is_load),
        .dec_is_store    (dec_is_store),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_resp_valid (dmem_resp_valid),
        .pc_we           (pc_we),
        .rf_we           (rf_we),
        .retire          (retire),
        .halted          (halted),
        .bus_err         (bus_err)
    );

    task automatic clear_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        dec_need_rd     = 1'b0;
        dec_is_load     = 1'b0;
        dec_is_store    = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Memory model: runs from FETCH until retire, halt, bus error or the cycle budget.
    task automatic exec_one(input logic [31:0] i_inst, input logic nrd, input logic ld,
                            input logic st, input int ireq_dly, input int iresp_dly,
                            input int dreq_dly, input int dresp_dly, input int max_cyc,
                            output int o_ivalid, output int o_dvalid, output int o_pcwe,
                            output int o_rfwe, output int o_ret_cyc, output int o_halt_cyc,
                            output int o_err_cyc);
        int iv_seen = 0, iwait = 0, dv_seen = 0, dwait = 0;
        bit iacc = 0, idone = 0, dacc = 0, ddone = 0;
        o_ivalid = 0; o_dvalid = 0; o_pcwe = 0; o_rfwe = 0;
        o_ret_cyc = -1; o_halt_cyc = -1; o_err_cyc = -1;
        dec_need_rd = nrd; dec_is_load = ld; dec_is_store = st;
        imem_resp_data = i_inst;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (imem_req_valid) o_ivalid++;
            if (dmem_req_valid) o_dvalid++;
            if (pc_we) o_pcwe++;
            if (rf_we) o_rfwe++;
            if (retire && o_ret_cyc < 0) begin
                o_ret_cyc = c;
                obs_q.push_back('{inst: inst, rf_we: rf_we, pc_we: pc_we});
            end
            if (halted && o_halt_cyc < 0) o_halt_cyc = c;
            if (bus_err && o_err_cyc < 0) o_err_cyc = c;
            imem_req_ready = imem_req_valid && (iv_seen >= ireq_dly);
            if (imem_req_valid) iv_seen++;
            imem_resp_valid = iacc && !idone && (iwait >= iresp_dly);
            if (iacc && !idone) begin
                if (imem_resp_valid) idone = 1;
                iwait++;
            end
            if (imem_req_valid && imem_req_ready) iacc = 1;
            dmem_req_ready = dmem_req_valid && (dv_seen >= dreq_dly);
            if (dmem_req_valid) dv_seen++;
            dmem_resp_valid = dacc && !ddone && (dwait >= dresp_dly);
            if (dacc && !ddone) begin
                if (dmem_resp_valid) ddone = 1;
                dwait++;
            end
            if (dmem_req_valid && dmem_req_ready) dacc = 1;
            if (retire || halted || bus_err) break;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({imem_req_valid, dmem_req_valid, pc_we, rf_we, retire, halted, bus_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {imem_req_valid, dmem_req_valid, pc_we, rf_we, retire, halted, bus_err});
        end
        n_cmp++;
        if (inst !== c_NOP) begin
            n_err++;
            $display("FAIL reset_inst: got %h expected %h", inst, c_NOP);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_fetch: imem_req_valid got %b expected 1", imem_req_valid);
        end
    endtask

    task automatic test_alu();
        int iv, dv, pcw, rfw, rc, hc, ec;
        exp_q.push_back('{inst: 32'h0050_0093, rf_we: 1'b1, pc_we: 1'b1});
        exec_one(32'h0050_0093, 1, 0, 0, 0, 0, 0, 0, 12, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (rc !== 3 || iv !== 1 || pcw !== 1 || rfw !== 1) begin
            n_err++;
            $display("FAIL alu_timing: retire_cyc=%0d ivalid=%0d pc_we=%0d rf_we=%0d expected 3 1 1 1",
                     rc, iv, pcw, rfw);
        end
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL alu_refetch: imem_req_valid got %b expected 1 in cycle 4", imem_req_valid);
        end
        while (exp_q.size() > 0) begin
            ret_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL alu_scoreboard: no retire observed, expected %h", e);
            end else begin
                ret_t o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL alu_scoreboard: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_load_store();
        int iv, dv, pcw, rfw, rc, hc, ec;
        exp_q.push_back('{inst: 32'h0040_2103, rf_we: 1'b1, pc_we: 1'b1});
        exec_one(32'h0040_2103, 1, 1, 0, 3, 0, 2, 5, 40, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (rc !== 15 || iv !== 4 || dv !== 3 || rfw !== 1 || pcw !== 1) begin
            n_err++;
            $display("FAIL load_timing: retire_cyc=%0d ivalid=%0d dvalid=%0d rf_we=%0d pc_we=%0d expected 15 4 3 1 1",
                     rc, iv, dv, rfw, pcw);
        end
        exp_q.push_back('{inst: 32'h0011_2223, rf_we: 1'b0, pc_we: 1'b1});
        exec_one(32'h0011_2223, 1, 0, 1, 0, 1, 1, 2, 40, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (rc !== 9 || pcw !== 1 || rfw !== 0) begin
            n_err++;
            $display("FAIL store_wb: retire_cyc=%0d pc_we=%0d rf_we=%0d expected 9 1 0", rc, pcw, rfw);
        end
        while (exp_q.size() > 0) begin
            ret_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL ldst_scoreboard: no retire observed, expected %h", e);
            end else begin
                ret_t o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL ldst_scoreboard: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_ebreak();
        int iv, dv, pcw, rfw, rc, hc, ec;
        int extra_iv = 0, extra_ret = 0, not_halted = 0;
        exec_one(c_EBREAK, 0, 0, 0, 0, 0, 0, 0, 10, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (hc !== 3 || rc !== -1 || ec !== -1) begin
            n_err++;
            $display("FAIL ebreak_halt: halt_cyc=%0d retire_cyc=%0d err_cyc=%0d expected 3 -1 -1", hc, rc, ec);
        end
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (imem_req_valid) extra_iv++;
            if (retire || pc_we || rf_we) extra_ret++;
            if (!halted) not_halted++;
        end
        n_cmp++;
        if (extra_iv !== 0 || extra_ret !== 0 || not_halted !== 0) begin
            n_err++;
            $display("FAIL ebreak_hold: ivalid=%0d strobes=%0d unhalted=%0d expected 0 0 0",
                     extra_iv, extra_ret, not_halted);
        end
    endtask

    task automatic test_timeout();
        int iv, dv, pcw, rfw, rc, hc, ec;
        int bad = 0;
        exec_one(32'h0050_0093, 1, 0, 0, 0, 1000, 0, 0, 30, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (ec !== c_TIMEOUT + 1 || rc !== -1) begin
            n_err++;
            $display("FAIL timeout_err: err_cyc=%0d retire_cyc=%0d expected %0d -1", ec, rc, c_TIMEOUT + 1);
        end
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus_err || imem_req_valid || dmem_req_valid || pc_we || rf_we || retire) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL timeout_sticky: bad_cycles got %0d expected 0", bad);
        end
        do_reset();
        exp_q.push_back('{inst: 32'h0050_0093, rf_we: 1'b1, pc_we: 1'b1});
        exec_one(32'h0050_0093, 1, 0, 0, 0, c_TIMEOUT - 1, 0, 0, 30, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (ec !== -1 || rc !== c_TIMEOUT + 2) begin
            n_err++;
            $display("FAIL timeout_edge: err_cyc=%0d retire_cyc=%0d expected -1 %0d", ec, rc, c_TIMEOUT + 2);
        end
        while (exp_q.size() > 0) begin
            ret_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL timeout_scoreboard: no retire observed, expected %h", e);
            end else begin
                ret_t o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL timeout_scoreboard: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mwait();
        int iv, dv, pcw, rfw, rc, hc, ec;
        exec_one(32'h0040_2103, 1, 1, 0, 0, 0, 0, 100, 6, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (inst !== 32'h0040_2103 || rc !== -1) begin
            n_err++;
            $display("FAIL mwait_setup: inst=%h retire_cyc=%0d expected 00402103 -1", inst, rc);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_valid, dmem_req_valid, pc_we, rf_we, retire, halted, bus_err} !== 7'b0
            || inst !== c_NOP) begin
            n_err++;
            $display("FAIL mwait_async_reset: outs=%b inst=%h expected 0000000 %h",
                     {imem_req_valid, dmem_req_valid, pc_we, rf_we, retire, halted, bus_err}, inst, c_NOP);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back('{inst: 32'h0050_0093, rf_we: 1'b1, pc_we: 1'b1});
        exec_one(32'h0050_0093, 1, 0, 0, 0, 0, 0, 0, 12, iv, dv, pcw, rfw, rc, hc, ec);
        n_cmp++;
        if (rc !== 3 || iv !== 1) begin
            n_err++;
            $display("FAIL mwait_restart: retire_cyc=%0d ivalid=%0d expected 3 1", rc, iv);
        end
        while (exp_q.size() > 0) begin
            ret_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL mwait_scoreboard: no retire observed, expected %h", e);
            end else begin
                ret_t o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL mwait_scoreboard: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl_inst [6] = '{32'h0050_0093, 32'h0040_2103, 32'h0011_2223,
                                      32'h0020_8133, 32'h0000_0013, 32'h0040_2183};
        logic [2:0]  tbl_dec  [6] = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b000, 3'b111};
        for (int k = 0; k < 6; k++) begin
            int iv, dv, pcw, rfw, rc, hc, ec;
            int a = $urandom_range(0, 5), b = $urandom_range(0, 5);
            int d = $urandom_range(0, 5), f = $urandom_range(0, 5);
            logic nrd = tbl_dec[k][2], ld = tbl_dec[k][1], st = tbl_dec[k][0];
            int exp_rc = (a + 1) + (b + 1) + 1 + ((ld || st) ? (d + 1) + (f + 1) : 0);
            exp_q.push_back('{inst: tbl_inst[k], rf_we: nrd & ~st, pc_we: 1'b1});
            exec_one(tbl_inst[k], nrd, ld, st, a, b, d, f, 60, iv, dv, pcw, rfw, rc, hc, ec);
            n_cmp++;
            if (rc !== exp_rc || iv !== a + 1 || dv !== ((ld || st) ? d + 1 : 0)) begin
                n_err++;
                $display("FAIL b2b_timing[%0d]: retire_cyc=%0d ivalid=%0d dvalid=%0d expected %0d %0d %0d",
                         k, rc, iv, dv, exp_rc, a + 1, (ld || st) ? d + 1 : 0);
            end
        end
        while (exp_q.size() > 0) begin
            ret_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL b2b_scoreboard: no retire observed, expected %h", e);
            end else begin
                ret_t o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL b2b_scoreboard: got %h expected %h", o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_back_to_back();
        test_ebreak();
        do_reset();
        test_timeout();
        do_reset();
        test_reset_mid_mwait();
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_err++;
            $display("FAIL stray_retires: got %0d unexpected retires expected 0", obs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
